// File: rtl/sirv_qspi_pkg.sv
// Shared types for the QSPI flash-map burst reader: FSM states, io_ctrl field
// layout, link protocol encodings and the protocol-to-bit-count helper.
package sirv_qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_PAD,
    ST_DRX_TX,
    ST_DRX_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    PROTO_SINGLE = 2'd0,
    PROTO_DUAL   = 2'd1,
    PROTO_QUAD   = 2'd2,
    PROTO_RSVD   = 2'd3
  } proto_e;

  // io_ctrl layout, packed LSB first in field order
  localparam int CTRL_W          = 31;
  localparam int CMD_PROTO_LSB   = 0;
  localparam int CMD_PROTO_W     = 2;
  localparam int CMD_CODE_LSB    = 2;
  localparam int CMD_CODE_W      = 8;
  localparam int CMD_EN_LSB      = 10;
  localparam int ADDR_PROTO_LSB  = 11;
  localparam int ADDR_PROTO_W    = 2;
  localparam int ADDR_LEN_LSB    = 13;
  localparam int ADDR_LEN_W      = 3;
  localparam int PAD_CODE_LSB    = 16;
  localparam int PAD_CODE_W      = 8;
  localparam int PAD_CNT_LSB     = 24;
  localparam int PAD_CNT_W       = 4;
  localparam int DATA_PROTO_LSB  = 28;
  localparam int DATA_PROTO_W    = 2;
  localparam int ENDIAN_LSB      = 30;

  localparam logic [2:0] MAX_ADDR_BYTES = 3'd4;

  // Link clock count needed to move one byte in a given protocol
  function automatic logic [7:0] proto_bits(input logic [1:0] proto);
    case (proto_e'(proto))
      PROTO_SINGLE: return 8'd8;
      PROTO_DUAL:   return 8'd4;
      PROTO_QUAD:   return 8'd2;
      default:      return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/sirv_qspi_beat_asm.sv
// Byte-lane assembler: fills one DATA_BYTES-wide read beat from received bytes,
// lane 0 first, and flags the load that completes the beat.
module sirv_qspi_beat_asm #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [7:0]              byte_i,
  output logic                    valid_o,
  output logic [8*DATA_BYTES-1:0] data_o
);

  localparam int BIDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BYTES - 1);

  logic [BIDX_W-1:0]       bidx_q, bidx_d;
  logic [8*DATA_BYTES-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    bidx_d = bidx_q;
    data_d = data_q;
    if (clear_i) begin
      bidx_d = '0;
    end else if (load_i) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (bidx_q == BIDX_W'(i)) data_d[8*i +: 8] = byte_i;
      end
      bidx_d = (bidx_q == BIDX_LAST) ? '0 : bidx_q + 1'b1;
    end
  end

  // NOTE: the data register is reset too, so no stale beat is visible after a reset abort.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bidx_q <= '0;
      data_q <= '0;
    end else begin
      bidx_q <= bidx_d;
      data_q <= data_d;
    end
  end

  assign valid_o = load_i & ~clear_i & (bidx_q == BIDX_LAST);
  assign data_o  = data_q;

endmodule

// File: rtl/sirv_qspi_flashmap_burst.sv
// QSPI flash-map read engine: CMD/ADDR/PAD/data framing over the link, one beat
// per request. Define SIRV_QSPI_FLASHMAP_MERGE_EN to continue sequential reads.
module sirv_qspi_flashmap_burst
  import sirv_qspi_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_en,
  input  logic [30:0]             io_ctrl,
  input  logic                    io_req_valid,
  output logic                    io_req_ready,
  input  logic [31:0]             io_req_addr,
  output logic                    io_data_valid,
  input  logic                    io_data_ready,
  output logic [8*DATA_BYTES-1:0] io_data_bits,
  output logic                    io_link_tx_valid,
  input  logic                    io_link_tx_ready,
  output logic [7:0]              io_link_tx_bits,
  input  logic                    io_link_rx_valid,
  input  logic [7:0]              io_link_rx_bits,
  output logic [7:0]              io_link_cnt,
  output logic [1:0]              io_link_fmt_proto,
  output logic                    io_link_fmt_iodir,
  output logic                    io_link_fmt_endian,
  output logic                    io_link_cs_set,
  output logic                    io_link_cs_clear,
  output logic                    io_link_cs_hold,
  output logic                    io_link_lock,
  input  logic                    io_link_active
);

  logic [1:0] cmd_proto, addr_proto, data_proto;
  logic [7:0] cmd_code, pad_code;
  logic [2:0] addr_len, addr_cnt;
  logic [3:0] pad_cnt;
  logic       cmd_en;

  assign cmd_proto  = io_ctrl[CMD_PROTO_LSB  +: CMD_PROTO_W];
  assign cmd_code   = io_ctrl[CMD_CODE_LSB   +: CMD_CODE_W];
  assign cmd_en     = io_ctrl[CMD_EN_LSB];
  assign addr_proto = io_ctrl[ADDR_PROTO_LSB +: ADDR_PROTO_W];
  assign addr_len   = io_ctrl[ADDR_LEN_LSB   +: ADDR_LEN_W];
  assign pad_code   = io_ctrl[PAD_CODE_LSB   +: PAD_CODE_W];
  assign pad_cnt    = io_ctrl[PAD_CNT_LSB    +: PAD_CNT_W];
  assign data_proto = io_ctrl[DATA_PROTO_LSB +: DATA_PROTO_W];

  state_e      state_q, after_addr;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q;
  logic        req_fire, merge, rx_load, beat_done;

  assign addr_cnt   = (addr_len > MAX_ADDR_BYTES) ? MAX_ADDR_BYTES : addr_len;
  assign after_addr = (pad_cnt != 4'd0) ? ST_PAD : ST_DRX_TX;

  // Gating with reset keeps a request from firing (and pulsing cs_clear) while held in reset
  assign io_req_ready = (state_q == ST_IDLE) & io_en & ~reset;
  assign req_fire     = io_req_valid & io_req_ready;
  assign rx_load      = (state_q == ST_DRX_WAIT) & io_link_rx_valid;

`ifdef SIRV_QSPI_FLASHMAP_MERGE_EN
  logic [31:0] last_addr_q;

  assign merge = io_link_active & (io_req_addr == last_addr_q + 32'(DATA_BYTES));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_addr_q <= '0;
    else if ((state_q == ST_RESP) && io_data_ready) last_addr_q <= addr_q;
  end
`else
  logic unused_link_active;

  assign merge              = 1'b0;
  assign unused_link_active = io_link_active;
`endif

  // NOTE: state lives in always_ff with non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_fire) begin
          addr_q <= io_req_addr;
          if (merge) begin
            state_q <= ST_DRX_TX;
          end else if (cmd_en) begin
            state_q <= ST_CMD;
          end else if (addr_cnt != 3'd0) begin
            cnt_q   <= addr_cnt;
            state_q <= ST_ADDR;
          end else begin
            state_q <= after_addr;
          end
        end
        ST_CMD: if (io_link_tx_ready) begin
          cnt_q   <= addr_cnt;
          state_q <= ST_ADDR;
        end
        ST_ADDR: begin
          if (cnt_q == 3'd0) begin
            state_q <= after_addr;
          end else if (io_link_tx_ready) begin
            cnt_q <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_q <= after_addr;
          end
        end
        ST_PAD:    if (io_link_tx_ready) state_q <= ST_DRX_TX;
        ST_DRX_TX: if (io_link_tx_ready) state_q <= ST_DRX_WAIT;
        ST_DRX_WAIT: begin
          if (beat_done)    state_q <= ST_RESP;
          else if (rx_load) state_q <= ST_DRX_TX;
        end
        ST_RESP:   if (io_data_ready) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  logic [7:0] addr_byte;
  logic [1:0] proto;
  logic       use_pad_cnt;

  always_comb begin
    case (cnt_q)
      3'd1:    addr_byte = addr_q[7:0];
      3'd2:    addr_byte = addr_q[15:8];
      3'd3:    addr_byte = addr_q[23:16];
      3'd4:    addr_byte = addr_q[31:24];
      default: addr_byte = 8'h00;
    endcase
  end

  always_comb begin
    io_link_tx_valid  = 1'b0;
    io_link_tx_bits   = 8'h00;
    io_link_fmt_iodir = 1'b0;
    proto             = data_proto;
    use_pad_cnt       = 1'b0;
    case (state_q)
      ST_CMD: begin
        io_link_tx_valid  = 1'b1;
        io_link_tx_bits   = cmd_code;
        io_link_fmt_iodir = 1'b1;
        proto             = cmd_proto;
      end
      ST_ADDR: begin
        io_link_tx_valid  = (cnt_q != 3'd0);
        io_link_tx_bits   = addr_byte;
        io_link_fmt_iodir = 1'b1;
        proto             = addr_proto;
      end
      ST_PAD: begin
        io_link_tx_valid  = 1'b1;
        io_link_tx_bits   = pad_code;
        io_link_fmt_iodir = 1'b1;
        proto             = addr_proto;
        use_pad_cnt       = 1'b1;
      end
      ST_DRX_TX: io_link_tx_valid = 1'b1;
      default: ;
    endcase
  end

  assign io_link_cnt        = use_pad_cnt ? {4'd0, pad_cnt} : proto_bits(proto);
  assign io_link_fmt_proto  = proto;
  assign io_link_fmt_endian = io_ctrl[ENDIAN_LSB];
  assign io_link_cs_set     = 1'b1;
  assign io_link_cs_hold    = 1'b1;
  assign io_link_cs_clear   = req_fire & ~merge;
  assign io_link_lock       = (state_q != ST_IDLE);
  assign io_data_valid      = (state_q == ST_RESP);

  sirv_qspi_beat_asm #(
    .DATA_BYTES(DATA_BYTES)
  ) u_beat_asm (
    .clock   (clock),
    .reset   (reset),
    .clear_i (req_fire),
    .load_i  (rx_load),
    .byte_i  (io_link_rx_bits),
    .valid_o (beat_done),
    .data_o  (io_data_bits)
  );

endmodule

// File: tb/tb_sirv_qspi_flashmap_burst.sv
// Randomized self-checking bench for sirv_qspi_flashmap_burst: a frame-list
// reference model plus a simple link responder with random stalls.
module tb_sirv_qspi_flashmap_burst;

  localparam int DB = 4;

  typedef struct packed {
    logic       endian;
    logic [1:0] data_proto;
    logic [3:0] pad_cnt;
    logic [7:0] pad_code;
    logic [2:0] addr_len;
    logic [1:0] addr_proto;
    logic       cmd_en;
    logic [7:0] cmd_code;
    logic [1:0] cmd_proto;
  } ctrl_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_en;
  logic [30:0]   io_ctrl;
  logic          io_req_valid;
  logic          io_req_ready;
  logic [31:0]   io_req_addr;
  logic          io_data_valid;
  logic          io_data_ready;
  logic [8*DB-1:0] io_data_bits;
  logic          io_link_tx_valid;
  logic          io_link_tx_ready;
  logic [7:0]    io_link_tx_bits;
  logic          io_link_rx_valid;
  logic [7:0]    io_link_rx_bits;
  logic [7:0]    io_link_cnt;
  logic [1:0]    io_link_fmt_proto;
  logic          io_link_fmt_iodir;
  logic          io_link_fmt_endian;
  logic          io_link_cs_set;
  logic          io_link_cs_clear;
  logic          io_link_cs_hold;
  logic          io_link_lock;
  logic          io_link_active;

  always #5 clock = ~clock;

  sirv_qspi_flashmap_burst #(.DATA_BYTES(DB)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_en              (io_en),
    .io_ctrl            (io_ctrl),
    .io_req_valid       (io_req_valid),
    .io_req_ready       (io_req_ready),
    .io_req_addr        (io_req_addr),
    .io_data_valid      (io_data_valid),
    .io_data_ready      (io_data_ready),
    .io_data_bits       (io_data_bits),
    .io_link_tx_valid   (io_link_tx_valid),
    .io_link_tx_ready   (io_link_tx_ready),
    .io_link_tx_bits    (io_link_tx_bits),
    .io_link_rx_valid   (io_link_rx_valid),
    .io_link_rx_bits    (io_link_rx_bits),
    .io_link_cnt        (io_link_cnt),
    .io_link_fmt_proto  (io_link_fmt_proto),
    .io_link_fmt_iodir  (io_link_fmt_iodir),
    .io_link_fmt_endian (io_link_fmt_endian),
    .io_link_cs_set     (io_link_cs_set),
    .io_link_cs_clear   (io_link_cs_clear),
    .io_link_cs_hold    (io_link_cs_hold),
    .io_link_lock       (io_link_lock),
    .io_link_active     (io_link_active)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_addr_m = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] bits_for(input logic [1:0] p);
    case (p)
      2'd0:    return 8'd8;
      2'd1:    return 8'd4;
      2'd2:    return 8'd2;
      default: return 8'd0;
    endcase
  endfunction

  // One read request end to end. abort_after>0 pulses reset after that many rx bytes.
  task automatic run_txn(input ctrl_t c, input logic [31:0] addr, input bit active,
                         input int max_stall, input int resp_stall, input bit use_fixed,
                         input logic [31:0] fixed_rx, input int abort_after, input bit en_drop);
    logic [16:0]     exp_q[$];
    logic [16:0]     got_q[$];
    logic [16:0]     mask;
    logic [8*DB-1:0] exp_data, held;
    logic [7:0]      b;
    bit              merge, accepted, done;
    int              n_rx, rx_wait, cyc, acc_cyc, dv_cyc, extra_clear, unstable;
    int              n_pre, extra, nbytes;

    exp_data = '0; held = '0; accepted = 0; done = 0; n_rx = 0; rx_wait = -1;
    cyc = 0; acc_cyc = -1; dv_cyc = -1; extra_clear = 0; unstable = 0; extra = 0;
`ifdef SIRV_QSPI_FLASHMAP_MERGE_EN
    merge = active && (addr == last_addr_m + 32'(DB));
`else
    merge = 1'b0;
`endif
    if (!merge) begin
      if (c.cmd_en) exp_q.push_back({1'b1, bits_for(c.cmd_proto), c.cmd_code});
      nbytes = (c.addr_len > 3'd4) ? 4 : int'(c.addr_len);
      for (int k = nbytes - 1; k >= 0; k--) begin
        b = 8'(addr >> (8 * k));
        exp_q.push_back({1'b1, bits_for(c.addr_proto), b});
      end
      if (c.pad_cnt != 4'd0) exp_q.push_back({1'b1, {4'd0, c.pad_cnt}, c.pad_code});
      if (c.cmd_en && nbytes == 0) extra = 1;
    end
    n_pre = exp_q.size();
    for (int k = 0; k < DB; k++) exp_q.push_back({1'b0, bits_for(c.data_proto), 8'h00});

    @(negedge clock);
    io_ctrl        = c;
    io_req_addr    = addr;
    io_link_active = active;
    io_req_valid   = 1'b1;
    while (!done && cyc < 2000) begin
      if (abort_after > 0 && n_rx >= abort_after) begin
        reset            = 1'b1;
        io_req_valid     = 1'b1;
        io_link_rx_valid = 1'b0;
        io_data_ready    = 1'b1;
        #1;
        check("rst_tx_valid", 64'(io_link_tx_valid), 64'd0);
        check("rst_data_valid", 64'(io_data_valid), 64'd0);
        check("rst_lock", 64'(io_link_lock), 64'd0);
        check("rst_cs_clear", 64'(io_link_cs_clear), 64'd0);
        check("rst_data_bits", 64'(io_data_bits), 64'd0);
        repeat (3) @(negedge clock);
        check("rst_hold_data_valid", 64'(io_data_valid), 64'd0);
        check("rst_hold_cs_clear", 64'(io_link_cs_clear), 64'd0);
        reset         = 1'b0;
        io_req_valid  = 1'b0;
        io_data_ready = 1'b0;
        last_addr_m   = '0;
        return;
      end
      if (accepted) begin
        io_req_valid = 1'b0;
        if (en_drop) io_en = 1'b0;
      end
      io_link_tx_ready = (max_stall == 0) ? 1'b1 : ($urandom_range(0, max_stall) == 0);
      io_link_rx_valid = 1'b0;
      if (rx_wait == 0) begin
        b = use_fixed ? fixed_rx[8*n_rx +: 8] : 8'($urandom);
        io_link_rx_valid = 1'b1;
        io_link_rx_bits  = b;
        if (n_rx < DB) exp_data[8*n_rx +: 8] = b;
        n_rx++;
        rx_wait = -1;
      end else if (rx_wait > 0) begin
        rx_wait--;
      end else if ($urandom_range(0, 3) == 0) begin
        io_link_rx_valid = 1'b1;          // stray byte while no beat read is pending
        io_link_rx_bits  = 8'($urandom);
      end
      io_data_ready = io_data_valid &&
                      ((dv_cyc >= 0) ? (cyc - dv_cyc >= resp_stall) : (resp_stall == 0));
      #1;
      if (!accepted && io_req_valid && io_req_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
        check("cs_clear_on_accept", 64'(io_link_cs_clear), 64'(!merge));
      end else if (io_link_cs_clear) begin
        extra_clear++;
      end
      if (io_link_tx_valid && io_link_tx_ready) begin
        got_q.push_back({io_link_fmt_iodir, io_link_cnt, io_link_tx_bits});
        if (!io_link_fmt_iodir) rx_wait = (max_stall == 0) ? 0 : $urandom_range(0, 2);
      end
      if (io_data_valid) begin
        if (dv_cyc < 0) begin
          dv_cyc = cyc;
          held   = io_data_bits;
        end else if (io_data_bits !== held) begin
          unstable++;
        end
        if (io_data_ready) done = 1;
      end
      @(negedge clock);
      cyc++;
    end
    io_req_valid     = 1'b0;
    io_data_ready    = 1'b0;
    io_link_rx_valid = 1'b0;

    check("accepted", 64'(accepted), 64'd1);
    check("completed", 64'(done), 64'd1);
    check("frame_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      mask = exp_q[k][16] ? 17'h1ffff : 17'h1ff00;
      check($sformatf("frame%0d", k), 64'(got_q[k] & mask), 64'(exp_q[k] & mask));
    end
    check("data_bits", 64'(held), 64'(exp_data));
    check("extra_cs_clear", 64'(extra_clear), 64'd0);
    if (resp_stall > 0) check("stall_stable", 64'(unstable), 64'd0);
    if (max_stall == 0) check("latency", 64'(dv_cyc - acc_cyc), 64'(n_pre + extra + 2*DB + 1));
    check("endian", 64'(io_link_fmt_endian), 64'(c.endian));
    if (done) last_addr_m = addr;

    if (en_drop) begin
      io_req_valid = 1'b1;
      repeat (4) begin
        @(negedge clock);
        #1;
        check("en_low_no_ready", 64'(io_req_ready), 64'd0);
      end
      check("en_low_idle", 64'(io_link_lock), 64'd0);
      io_req_valid = 1'b0;
      io_en        = 1'b1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ctrl_t       c0, c1, cr;
    logic [31:0] a;
    bit          act;

    reset            = 1'b1;
    io_en            = 1'b1;
    io_ctrl          = '0;
    io_req_valid     = 1'b1;
    io_req_addr      = '0;
    io_data_ready    = 1'b0;
    io_link_tx_ready = 1'b1;
    io_link_rx_valid = 1'b0;
    io_link_rx_bits  = '0;
    io_link_active   = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    check("init_tx_valid", 64'(io_link_tx_valid), 64'd0);
    check("init_data_valid", 64'(io_data_valid), 64'd0);
    check("init_lock", 64'(io_link_lock), 64'd0);
    check("init_cs_clear", 64'(io_link_cs_clear), 64'd0);
    check("init_data_bits", 64'(io_data_bits), 64'd0);
    reset        = 1'b0;
    io_req_valid = 1'b0;
    @(negedge clock);
    #1;
    check("idle_req_ready", 64'(io_req_ready), 64'd1);
    check("idle_cs_set", 64'(io_link_cs_set), 64'd1);
    check("idle_cs_hold", 64'(io_link_cs_hold), 64'd1);
    check("idle_lock", 64'(io_link_lock), 64'd0);

    // Fast-read: cmd 0x0B, 3 address bytes, 8 dummy clocks
    c0 = '0;
    c0.cmd_en   = 1'b1;
    c0.cmd_code = 8'h0B;
    c0.addr_len = 3'd3;
    c0.pad_cnt  = 4'd8;
    c0.pad_code = 8'h00;
    run_txn(c0, 32'h0012_3450, 1'b0, 0, 0, 1'b1, 32'h4433_2211, 0, 1'b0);
    // Sequential follow-up with CS still active
    run_txn(c0, 32'h0012_3454, 1'b1, 0, 0, 1'b1, 32'h8877_6655, 0, 1'b0);
    // No command, no address, no padding
    c1 = '0;
    run_txn(c1, 32'h0000_0100, 1'b0, 0, 0, 1'b0, 32'h0, 0, 1'b0);
    // Response held off for 10 cycles, then a normal request
    run_txn(c0, 32'h0000_2000, 1'b0, 2, 10, 1'b0, 32'h0, 0, 1'b0);
    run_txn(c0, 32'h0000_2040, 1'b0, 0, 0, 1'b0, 32'h0, 0, 1'b0);
    // Enable dropped mid-transaction
    run_txn(c0, 32'h0000_2080, 1'b0, 1, 1, 1'b0, 32'h0, 0, 1'b1);
    // Reset after two received bytes, then a fresh request
    run_txn(c0, 32'h0000_3000, 1'b0, 0, 0, 1'b0, 32'h0, 2, 1'b0);
    run_txn(c0, 32'h0000_3004, 1'b1, 0, 0, 1'b0, 32'h0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      cr  = ctrl_t'(31'($urandom));
      act = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) a = last_addr_m + 32'(DB);
      else a = $urandom & ~32'(DB - 1);
      run_txn(cr, a, act, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 32'h0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sirv_qspi_flashmap_burst.md
SIRV_QSPI_FLASHMAP_BURST -- requirements
Module: sirv_qspi_flashmap_burst

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, which sets the bytes per read beat; legal values are 1, 2 and 4.
REQ-002 SHALL have ports: clock  in  1  clock.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 io_en  in  1  flash-map enable.
REQ-005 io_ctrl  in  31  packed instruction word: cmd_proto, cmd_code, cmd_en, addr_proto, addr_len, pad_code, pad_cnt, data_proto, endian.
REQ-006 io_req_valid / io_req_ready  in / out  1 / 1  read-request handshake.
REQ-007 io_req_addr  in  32  byte address, DATA_BYTES-aligned.
REQ-008 io_data_valid / io_data_ready  out / in  1 / 1  response handshake.
REQ-009 io_data_bits  out  8*DATA_BYTES  assembled read data.
REQ-010 io_link_tx_valid / io_link_tx_ready / io_link_tx_bits  out / in / out  1 / 1 / 8  link frame.
REQ-011 io_link_rx_valid / io_link_rx_bits  in / in  1 / 8  received byte.
REQ-012 io_link_cnt / io_link_fmt_proto / io_link_fmt_iodir / io_link_fmt_endian  out  8 / 2 / 1 / 1  frame format.
REQ-013 io_link_cs_set / io_link_cs_clear / io_link_cs_hold / io_link_lock  out  1 each  chip-select control and link lock.
REQ-014 io_link_active  in  1  CS still asserted from the previous transaction.

Function
REQ-015 SHALL implement states IDLE, CMD, ADDR, PAD, DRX_TX, DRX_WAIT, RESP.
REQ-016 IDLE: io_req_ready = io_en; on req fire, latch the address into addr_q. If merge holds, go to DRX_TX; else go to CMD if cmd_en, else ADDR. cs_clear = fire & !merge for one cycle.
REQ-017 merge SHALL equal io_link_active & (io_req_addr == last_addr_q + DATA_BYTES), using 32-bit wrap-around arithmetic.
REQ-018 CMD: tx_bits=cmd_code, proto=cmd_proto, iodir=1; on tx_ready go to ADDR and load cnt=min(addr_len,4).
REQ-019 ADDR: send byte addr_q[8*cnt-1 -: 8] (MSB first) and decrement cnt on each tx fire. Leave after the cnt==1 fire, or immediately if cnt==0 on entry. Exit to PAD if pad_cnt!=0, else to DRX_TX.
REQ-020 PAD: tx_bits=pad_code, io_link_cnt=pad_cnt; on tx_ready go to DRX_TX.
REQ-021 DRX_TX: tx_valid=1, iodir=0, proto=data_proto; on tx_ready go to DRX_WAIT.
REQ-022 DRX_WAIT: on rx_valid, store rx_bits into byte lane bidx of the data register (bidx 0 → bits [7:0]) and increment bidx. Go to DRX_TX if bidx < DATA_BYTES-1, else go to RESP with bidx cleared.
REQ-023 RESP: io_data_valid=1 holding the registered word. On data_ready, set last_addr_q=addr_q and go to IDLE. Data is stable while stalled.
REQ-024 io_link_cnt outside PAD SHALL be 8/4/2 for proto 0/1/2, and 0 for proto 3.
REQ-025 SHALL drive io_link_tx_valid only in CMD, ADDR, PAD and DRX_TX.
REQ-026 SHALL hold cs_set=1 and cs_hold=1 at all times, and io_link_lock=1 in every state except IDLE.
REQ-027 io_link_fmt_endian SHALL follow the endian field of io_ctrl.
REQ-028 SHALL let an io_en drop mid-transaction finish the transaction; IDLE then accepts nothing.
REQ-029 SHALL ignore rx_valid outside DRX_WAIT.
REQ-030 Latency with no merge, cmd_en=1, addr_len=3, pad_cnt!=0 and zero-stall link: 5 tx frames before the first data frame, then 2 cycles per byte. Data_valid is asserted the cycle after the last rx_valid.

Reset
REQ-031 Reset SHALL set state=IDLE, cnt=0, bidx=0, data register=0, addr_q=0 and last_addr_q=0.
REQ-032 During reset, outputs SHALL be tx_valid=0, data_valid=0, lock=0 and cs_clear=0.
REQ-033 Reset asserted mid-burst SHALL abort immediately with no partial data_valid.

Configuration
REQ-034 SHALL support macro SIRV_QSPI_FLASHMAP_MERGE_EN. When defined, merge follows REQ-017. When undefined, merge is tied to 0: every request asserts cs_clear and runs the full CMD/ADDR/PAD sequence, and last_addr_q is removed.

Structure
REQ-035 Package sirv_qspi_pkg SHALL hold the state enum, the io_ctrl field offsets/widths, the proto encodings and the proto-to-bit-count function.
REQ-036 Sub-module sirv_qspi_beat_asm SHALL perform byte-lane assembly (bidx counter plus data register, with load/clear/valid).

Verification
REQ-037 DATA_BYTES=4; cmd_en=1, cmd_code=0x0B, addr_len=3, pad_cnt=8, pad_code=0x00; req 0x00123450; rx 11,22,33,44 → tx bytes 0B,12,34,50,00, then 4 rx frames; data_bits=0x44332211.
REQ-038 Follow-up req 0x00123454 with link_active=1 → no cs_clear, no CMD/ADDR; first tx in DRX_TX; with MERGE_EN undefined → full sequence repeats.
REQ-039 addr_len=0, pad_cnt=0, cmd_en=0 → IDLE goes directly to DRX_TX; the 4-byte beat completes.
REQ-040 data_ready held low 10 cycles in RESP → data_valid and data_bits stable; the request after release is accepted.
REQ-041 Reset pulsed after 2 rx bytes → IDLE, all outputs 0; the next request starts with cs_clear=1 and a fresh beat.
